// File: rtl/vga_rx_decoder_if.sv
// vga_rx_decoder_if: sampled VGA input stream and reconstructed pixel stream
interface vga_rx_decoder_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic [7:0]  err_count;

    modport master (
        output pix_en, hsync, vsync, r, g, b,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_count
    );

    modport slave (
        input  pix_en, hsync, vsync, r, g, b,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_count
    );
endinterface

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: locks to VGA sync timing and rebuilds a valid-qualified pixel stream
module vga_rx_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input logic clk,
    input logic rst,
    vga_rx_decoder_if.slave bus
);
    localparam logic [9:0] H_TOTAL = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [9:0] V_TOTAL = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]  state, state_next;
    logic [9:0]  h_cnt, v_cnt, h_next, v_next;
    logic        hs_prev, vs_prev;
    logic        hs_on, vs_on, h_edge, v_edge;
    logic        line_err, frame_err, any_err, in_win, valid_next;
    logic        pix_valid_q, frame_start_q;
    logic [9:0]  pix_x_q, pix_y_q;
    logic [11:0] pix_rgb_q;
    logic [7:0]  err_count_q;

    // decode edges, next counters, timing errors and the next lock state for this sample
    always_comb begin
        hs_on      = bus.hsync == SYNC_POL;
        vs_on      = bus.vsync == SYNC_POL;
        h_edge     = hs_on && !hs_prev;
        v_edge     = h_edge && vs_on && !vs_prev;
        h_next     = h_edge ? 10'd0 : (h_cnt == H_TOTAL ? h_cnt : h_cnt + 10'd1);
        v_next     = v_edge ? 10'd0 : (h_edge && v_cnt != V_TOTAL) ? v_cnt + 10'd1 : v_cnt;
        line_err   = state != HUNT && (h_edge ? h_cnt != H_TOTAL - 10'd1 : h_cnt == H_TOTAL - 10'd1);
        frame_err  = state != HUNT && v_edge && v_cnt != V_TOTAL - 10'd1;
        any_err    = line_err || frame_err;
        state_next = state == HUNT ? (v_edge ? CHECK : HUNT) :
                     any_err ? HUNT :
                     (state == CHECK && v_edge) ? LOCKED : state;
        in_win     = h_next >= H_START && h_next <= H_END && v_next >= V_START && v_next <= V_END;
        valid_next = state_next == LOCKED && in_win;
    end

    // advance timing state and register the pixel outputs on each strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            h_cnt         <= '0;
            v_cnt         <= '0;
            hs_prev       <= 1'b0;
            vs_prev       <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            err_count_q   <= '0;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            if (bus.pix_en) begin
                state         <= state_next;
                h_cnt         <= h_next;
                v_cnt         <= v_next;
                hs_prev       <= hs_on;
                vs_prev       <= h_edge ? vs_on : vs_prev;
                pix_valid_q   <= valid_next;
                frame_start_q <= valid_next && h_next == H_START && v_next == V_START;
                if (valid_next) begin
                    pix_x_q   <= h_next - H_START;
                    pix_y_q   <= v_next - V_START;
                    pix_rgb_q <= {bus.r, bus.g, bus.b};
                end
                if (state == LOCKED && any_err && err_count_q != 8'hFF)
                    err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign bus.pix_valid   = pix_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_rgb     = pix_rgb_q;
    assign bus.err_count   = err_count_q;
    assign bus.locked      = state == LOCKED;
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: directed frame sequences with random strobe gaps and colours against a lock model
module tb_vga_rx_decoder;
    localparam int HA = 4, HF = 2, HS = 2, HB = 2;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rx_decoder_if bus();

    vga_rx_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0, n_bad = 0;
    int line_pos, lines, lvl, errs;
    bit last_hs, last_vs;
    int gap_max = 1, gap_l = -1, gap_at = -1;
    int cnt_valid, cnt_fs;
    logic [11:0] fs_rgb, end_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        line_pos = 0; lines = 0; lvl = 0; errs = 0;
        last_hs = 1'b0; last_vs = 1'b0;
    endtask

    // lock model: lvl 0 = hunting, 1 = checking, 2 = locked; positions measured in samples/lines
    task automatic model_step(input bit hs, input bit vs);
        bit hedge, vedge, lerr, ferr;
        hedge = hs && !last_hs;
        last_hs = hs;
        vedge = 1'b0; lerr = 1'b0; ferr = 1'b0;
        if (hedge) begin
            lerr = lvl != 0 && line_pos != HT - 1;
            line_pos = 0;
            vedge = vs && !last_vs;
            last_vs = vs;
            if (vedge) begin
                ferr = lvl != 0 && lines != VT - 1;
                lines = 0;
            end else if (lines < VT) lines++;
        end else begin
            lerr = lvl != 0 && line_pos == HT - 1;
            if (line_pos < HT) line_pos++;
        end
        if (lvl == 0) begin
            if (vedge) lvl = 1;
        end else if (lerr || ferr) begin
            if (lvl == 2 && errs < 255) errs++;
            lvl = 0;
        end else if (lvl == 1 && vedge) lvl = 2;
    endtask

    task automatic observe(input bit ev, input int gx, input int gy, input logic [11:0] rgb);
        @(posedge clk);
        #1;
        chk("pix_valid", 32'(bus.pix_valid), 32'(ev));
        chk("frame_start", 32'(bus.frame_start), 32'(ev && gx == 0 && gy == 0));
        chk("locked", 32'(bus.locked), 32'(lvl == 2));
        chk("err_count", 32'(bus.err_count), 32'(errs));
        if (ev) begin
            chk("pix_x", 32'(bus.pix_x), 32'(gx));
            chk("pix_y", 32'(bus.pix_y), 32'(gy));
            chk("pix_rgb", 32'(bus.pix_rgb), 32'(rgb));
        end
        if (bus.pix_valid) cnt_valid++;
        if (bus.frame_start) begin
            cnt_fs++;
            fs_rgb = bus.pix_rgb;
        end
        if (bus.pix_valid && bus.pix_x == 10'(HA - 1) && bus.pix_y == 10'(VA - 1)) end_rgb = bus.pix_rgb;
    endtask

    task automatic idle();
        bus.pix_en = 1'b0;
        bus.hsync = 1'($urandom);
        bus.vsync = 1'($urandom);
        {bus.r, bus.g, bus.b} = 12'($urandom);
        observe(1'b0, -1, -1, 12'h0);
    endtask

    task automatic sample(input bit hs, input bit vs, input int gx, input int gy, input logic [11:0] rgb);
        repeat ($urandom_range(gap_max, 0)) idle();
        bus.pix_en = 1'b1;
        bus.hsync = !hs;
        bus.vsync = !vs;
        {bus.r, bus.g, bus.b} = rgb;
        model_step(hs, vs);
        observe(lvl == 2 && gx >= 0, gx, gy, rgb);
    endtask

    task automatic drive_line(input int len, input bit vs, input int y, input bit pattern);
        int gx;
        logic [11:0] c;
        for (int h = 0; h < len; h++) begin
            if (y == gap_l && h == gap_at) repeat (1000) idle();
            gx = (y >= 0 && h >= HS + HB && h < HS + HB + HA) ? h - (HS + HB) : -1;
            c = (pattern && gx >= 0) ? {4'(gx), 4'(y), 4'h5} : 12'($urandom);
            sample(h < HS, vs, gx, y, c);
        end
    endtask

    task automatic drive_frame(input int short_l, input bit pattern);
        int y;
        cnt_valid = 0;
        cnt_fs = 0;
        for (int l = 0; l < VT; l++) begin
            y = (l >= VS + VB && l < VS + VB + VA) ? l - (VS + VB) : -1;
            drive_line(l == short_l ? HT - 1 : HT, l < VS, y, pattern);
        end
    endtask

    initial begin
        bus.pix_en = 1'b0;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        {bus.r, bus.g, bus.b} = 12'h0;
        model_reset();
        rst = 1'b1;
        repeat (3) begin
            bus.pix_en = 1'($urandom);
            bus.hsync = 1'($urandom);
            bus.vsync = 1'($urandom);
            {bus.r, bus.g, bus.b} = 12'($urandom);
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(bus.pix_valid), 32'd0);
            chk("rst_x", 32'(bus.pix_x), 32'd0);
            chk("rst_y", 32'(bus.pix_y), 32'd0);
            chk("rst_rgb", 32'(bus.pix_rgb), 32'd0);
            chk("rst_fs", 32'(bus.frame_start), 32'd0);
            chk("rst_locked", 32'(bus.locked), 32'd0);
            chk("rst_err", 32'(bus.err_count), 32'd0);
        end
        rst = 1'b0;

        drive_frame(-1, 1'b1);
        chk("frame1_locked", 32'(bus.locked), 32'd0);
        chk("frame1_pixels", 32'(cnt_valid), 32'd0);
        for (int f = 2; f <= 3; f++) begin
            drive_frame(-1, 1'b1);
            chk("frame_locked", 32'(bus.locked), 32'd1);
            chk("frame_pixels", 32'(cnt_valid), 32'(HA * VA));
            chk("frame_starts", 32'(cnt_fs), 32'd1);
            chk("origin_rgb", 32'(fs_rgb), 32'h005);
            chk("corner_rgb", 32'(end_rgb), 32'({4'(HA - 1), 4'(VA - 1), 4'h5}));
        end

        gap_l = 1;
        gap_at = HS + HB + 1;
        drive_frame(-1, 1'b1);
        gap_l = -1;
        chk("gated_pixels", 32'(cnt_valid), 32'(HA * VA));
        chk("gated_starts", 32'(cnt_fs), 32'd1);

        drive_frame(2, 1'b0);
        chk("short_locked", 32'(bus.locked), 32'd0);
        chk("short_err", 32'(bus.err_count), 32'd1);
        drive_frame(-1, 1'b0);
        chk("short_check", 32'(bus.locked), 32'd0);
        drive_frame(-1, 1'b0);
        chk("short_relock", 32'(bus.locked), 32'd1);

        drive_line(HT + 10, 1'b0, -1, 1'b0);
        chk("nohsync_locked", 32'(bus.locked), 32'd0);
        chk("nohsync_err", 32'(bus.err_count), 32'd2);
        drive_frame(-1, 1'b0);
        drive_frame(-1, 1'b0);
        chk("nohsync_relock", 32'(bus.locked), 32'd1);

        gap_max = 0;
        repeat (300) begin
            drive_frame(VT - 2, 1'b0);
            drive_frame(-1, 1'b0);
        end
        chk("sat_err", 32'(bus.err_count), 32'd255);

        drive_line(HT, 1'b1, -1, 1'b0);
        drive_line(HT / 2, 1'b0, -1, 1'b0);
        rst = 1'b1;
        bus.pix_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("midrst_err", 32'(bus.err_count), 32'd0);
        chk("midrst_locked", 32'(bus.locked), 32'd0);
        chk("midrst_valid", 32'(bus.pix_valid), 32'd0);
        drive_frame(-1, 1'b0);
        chk("midrst_hunt", 32'(bus.locked), 32'd0);
        drive_frame(-1, 1'b0);
        chk("midrst_relock", 32'(bus.locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_rx_decoder.md
# vga_rx_decoder

Receive-side counterpart of the VGA renderer. It samples the hsync/vsync/r/g/b stream once per pixel strobe, locks to 640x480 timing, and reconstructs pixel coordinates and colour as a valid-qualified stream. It sits beside the render output for self-check and frame capture, e.g. feeding a frame-buffer writer or a CRC checker.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel strobe; one sample per cycle where high (the renderer's vga_clk divided-clock rate)
- hsync, vsync  in  1 each  sync inputs
- r, g, b  in  4 each  colour inputs
- pix_valid  out  1  a visible pixel is presented
- pix_x  out  10  column 0..H_ACTIVE-1
- pix_y  out  10  row 0..V_ACTIVE-1
- pix_rgb  out  12  {r,g,b} of the pixel
- frame_start  out  1  pulse together with pixel (0,0)
- locked  out  1  timing lock indicator
- err_count  out  8  timing violations, saturating at 255

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800). V_TOTAL = sum of the V parameters (525). Both counters are 10 bits wide.
- All state advances only on cycles with pix_en=1. When pix_en=0, state is held and pix_valid/frame_start are 0.
- hsync leading edge: the first sample with hsync asserted after a sample with it deasserted. On this edge h_cnt is set to 0. On other samples h_cnt increments, saturating at H_TOTAL.
- Line check at each leading edge (not the first after HUNT): the previous h_cnt must equal H_TOTAL-1, otherwise it is a line error. h_cnt reaching H_TOTAL with no edge is also a line error; flag it once per line.
- vsync is sampled only on hsync leading edges. A vsync leading edge (asserted now, deasserted at the previous hsync edge) sets v_cnt to 0. Otherwise v_cnt increments on each hsync edge, saturating at V_TOTAL.
- Frame check at a vsync leading edge: the previous v_cnt must equal V_TOTAL-1, otherwise it is a frame error.
- Active window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - pix_x = h_cnt-(H_SYNC+H_BP)
  - pix_y = v_cnt-(V_SYNC+V_BP)
- Lock FSM states: HUNT, CHECK, LOCKED.
  - HUNT: no checks. A vsync leading edge moves to CHECK.
  - CHECK: any line or frame error returns to HUNT (err_count unchanged). A vsync leading edge with a clean frame moves to LOCKED.
  - LOCKED: any line or frame error goes to HUNT and increments err_count. If both error types occur on the same sample, increment by 1 only.
- pix_valid=1 only in LOCKED and inside the active window, including the sample that causes the LOCKED entry.
- frame_start=1 exactly when pix_valid=1 with pix_x=0 and pix_y=0.
- The LOCKED to HUNT transition blanks pix_valid starting with the offending sample.
- locked=1 iff the state is LOCKED.

## Timing
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_start=0, locked=0, err_count=0, state=HUNT, h_cnt=0, v_cnt=0.
- Edge-detect history is cleared to "deasserted", so a sync already asserted at reset counts as an edge on the first strobe.
- Latency: all outputs are registered. Outputs reflect a pix_en sample on the cycle after it, and hold for exactly 1 clk.
- locked rises on the cycle after the sample that completes the first clean frame, i.e. the second vsync leading edge after reset.
- rst mid-frame: all state returns to reset values on the next clk edge, regardless of pix_en.

## Test plan
- Reset: assert rst for 3 clk with random inputs -> all outputs 0 and locked=0.
- Clean lock: feed 3 ideal 640x480 frames with pix_en every other clk and rgb = {x[3:0], y[3:0], 4'h5}.
  - locked rises after the 2nd vsync edge.
  - Frames 2-3 each give 307200 pix_valid pulses and one frame_start, at (0,0) with rgb 12'h005.
  - Pixel (639,479) has rgb 12'hFF5.
- Short line: while locked, one line of 799 samples -> locked falls at the next hsync edge and err_count=1. Relock after 2 further clean vsync edges.
- Missing hsync: while locked, hold hsync deasserted for 900 samples -> locked falls at sample 800 and err_count increments by 1 only.
- Strobe gating: hold pix_en=0 for 1000 clk mid-line -> no output pulses, and counters resume exactly where they stopped.
- Saturation/reset: inject 300 line errors while relocking each time -> err_count=255. Then assert rst mid-frame -> err_count=0, state HUNT.
